// File: rtl/hazard_forwarding_unit.sv
// Hazard/forwarding controller: tracks EX/MEM/WB destinations, resolves ID operands,
// and drives stall/flush controls. Optional stall counter enabled by HZ_PERF_CNT_EN.
module hazard_forwarding_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  ID_SA,
    input  logic [3:0]  ID_SB,
    input  logic [3:0]  ID_SD,
    input  logic        ID_USE_A,
    input  logic        ID_USE_B,
    input  logic        ID_USE_D,
    input  logic        ID_RFLD,
    input  logic [3:0]  ID_DEST,
    input  logic        ID_LOAD,
    input  logic        BR_TAKEN,
    input  logic        MEM_WAIT,
    input  logic [31:0] PA,
    input  logic [31:0] PB,
    input  logic [31:0] PD,
    input  logic [31:0] EX_RESULT,
    input  logic [31:0] MEM_RESULT,
    input  logic [31:0] WB_RESULT,
    output logic [31:0] OP_A,
    output logic [31:0] OP_B,
    output logic [31:0] OP_D,
`ifdef HZ_PERF_CNT_EN
    output logic [15:0] STALL_COUNT,
`endif
    output logic        HZPCld,
    output logic        IFID_LD,
    output logic        IFID_CLR,
    output logic        NOP_SEL
);

    typedef struct packed {
        logic       valid;
        logic [3:0] dest;
        logic       load;
    } slot_t;

    localparam slot_t      SLOT_EMPTY = 6'd0;
    localparam logic [3:0] PC_REG     = 4'd15;

    slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic  lu_s;
    logic  stall_s;

    // A load still in EX has no result yet, so it can only stall, never forward.
    function automatic logic load_hit(input logic [3:0] spec, input logic use_op);
        return use_op && (spec != PC_REG) && ex_q.valid && ex_q.load && (spec == ex_q.dest);
    endfunction

    function automatic logic [31:0] resolve(input logic [3:0] spec, input logic use_op,
                                            input logic [31:0] port);
        logic [31:0] val;
        if (!use_op || spec == PC_REG) begin
            val = port;
        end else if (ex_q.valid && !ex_q.load && ex_q.dest == spec) begin
            val = EX_RESULT;
        end else if (mem_q.valid && mem_q.dest == spec) begin
            val = MEM_RESULT;
        end else if (wb_q.valid && wb_q.dest == spec) begin
            val = WB_RESULT;
        end else begin
            val = port;
        end
        return val;
    endfunction

    assign lu_s    = load_hit(ID_SA, ID_USE_A) || load_hit(ID_SB, ID_USE_B) ||
                     load_hit(ID_SD, ID_USE_D);
    assign stall_s = lu_s && !MEM_WAIT;

    // Operand selection
    always_comb begin
        OP_A = resolve(ID_SA, ID_USE_A, PA);
        OP_B = resolve(ID_SB, ID_USE_B, PB);
        OP_D = resolve(ID_SD, ID_USE_D, PD);
    end

    // Tracker next state: shift down the pipe unless memory freezes it; stalls inject a bubble
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!MEM_WAIT) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (stall_s) begin
                ex_d = SLOT_EMPTY;
            end else begin
                ex_d = {ID_RFLD, ID_DEST, ID_LOAD};
            end
        end else begin
            ex_d  = ex_q;
            mem_d = mem_q;
            wb_d  = wb_q;
        end
    end

    // Tracker state registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_q  <= SLOT_EMPTY;
            mem_q <= SLOT_EMPTY;
            wb_q  <= SLOT_EMPTY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // Pipeline controls; reset keeps the PC load enabled so the PC reset takes effect
    always_comb begin
        HZPCld   = 1'b1;
        IFID_LD  = 1'b1;
        IFID_CLR = 1'b0;
        NOP_SEL  = 1'b0;
        if (RST) begin
            HZPCld   = 1'b1;
            IFID_LD  = 1'b1;
        end else if (MEM_WAIT) begin
            HZPCld   = 1'b0;
            IFID_LD  = 1'b0;
        end else if (lu_s) begin
            HZPCld   = 1'b0;
            IFID_LD  = 1'b0;
            NOP_SEL  = 1'b1;
        end else if (BR_TAKEN) begin
            IFID_CLR = 1'b1;
        end else begin
            HZPCld   = 1'b1;
            IFID_LD  = 1'b1;
        end
    end

`ifdef HZ_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles in which the PC is held
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!HZPCld && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign STALL_COUNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Bench for hazard_forwarding_unit: directed vector table, hand-built corner
// sequences and randomized traffic against an in-flight-instruction queue model.
module tb_hazard_forwarding_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sa, sb, sd, dest;
    logic        ua, ub, ud, rfld, ld, br, mw;
    logic [31:0] pa, pb, pd, exr, memr, wbr;
    logic [31:0] op_a, op_b, op_d;
    logic        hzpcld, ifid_ld, ifid_clr, nop_sel;
`ifdef HZ_PERF_CNT_EN
    logic [15:0] stall_count;
`endif

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_forwarding_unit dut (
        .CLK(clk), .RST(rst),
        .ID_SA(sa), .ID_SB(sb), .ID_SD(sd),
        .ID_USE_A(ua), .ID_USE_B(ub), .ID_USE_D(ud),
        .ID_RFLD(rfld), .ID_DEST(dest), .ID_LOAD(ld),
        .BR_TAKEN(br), .MEM_WAIT(mw),
        .PA(pa), .PB(pb), .PD(pd),
        .EX_RESULT(exr), .MEM_RESULT(memr), .WB_RESULT(wbr),
        .OP_A(op_a), .OP_B(op_b), .OP_D(op_d),
`ifdef HZ_PERF_CNT_EN
        .STALL_COUNT(stall_count),
`endif
        .HZPCld(hzpcld), .IFID_LD(ifid_ld), .IFID_CLR(ifid_clr), .NOP_SEL(nop_sel)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       valid;
        logic [3:0] dest;
        logic       load;
    } instr_t;

    instr_t      inflight[$];   // [0] in EX, [1] in MEM, [2] in WB
    int unsigned m_stalls;

    task automatic model_reset();
        inflight = {};
        for (int i = 0; i < 3; i++) inflight.push_back(instr_t'(6'd0));
        m_stalls = 0;
    endtask

    function automatic logic m_load_use();
        logic [3:0] s [3];
        logic       u [3];
        logic       hit;
        s = '{sa, sb, sd};
        u = '{ua, ub, ud};
        hit = 1'b0;
        for (int i = 0; i < 3; i++)
            if (u[i] && s[i] != 4'd15 && inflight[0].valid && inflight[0].load &&
                inflight[0].dest == s[i]) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [31:0] m_operand(input logic [3:0] s, input logic u,
                                              input logic [31:0] port);
        logic [31:0] res [3];
        res = '{exr, memr, wbr};
        if (!u || s == 4'd15) return port;
        for (int age = 0; age < 3; age++)
            if (inflight[age].valid && inflight[age].dest == s &&
                !(age == 0 && inflight[age].load)) return res[age];
        return port;
    endfunction

    // {HZPCld, IFID_LD, IFID_CLR, NOP_SEL}
    function automatic logic [3:0] m_ctl();
        if (rst)          return 4'b1100;
        if (mw)           return 4'b0000;
        if (m_load_use()) return 4'b0001;
        if (br)           return 4'b1110;
        return 4'b1100;
    endfunction

    task automatic model_clock();
        logic [3:0] c;
        instr_t     nx;
        if (rst) begin
            model_reset();
        end else begin
            c = m_ctl();
            if (!c[3] && m_stalls < 65535) m_stalls++;
            if (!mw) begin
                nx = m_load_use() ? instr_t'(6'd0) : instr_t'({rfld, dest, ld});
                void'(inflight.pop_back());
                inflight.push_front(nx);
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                                 input logic [31:0] ed, input logic [3:0] ec);
        chk({tag, ".op_a"}, op_a, ea);
        chk({tag, ".op_b"}, op_b, eb);
        chk({tag, ".op_d"}, op_d, ed);
        chk({tag, ".ctl"}, {28'd0, hzpcld, ifid_ld, ifid_clr, nop_sel}, {28'd0, ec});
    endtask

    task automatic check_count(input string tag);
`ifdef HZ_PERF_CNT_EN
        chk({tag, ".cnt"}, {16'd0, stall_count}, m_stalls);
`endif
    endtask

    task automatic check_model(input string tag);
        check_outputs(tag, m_operand(sa, ua, pa), m_operand(sb, ub, pb),
                      m_operand(sd, ud, pd), m_ctl());
        check_count(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    localparam logic [1:0] S_P = 2'd0, S_E = 2'd1, S_M = 2'd2, S_W = 2'd3;
    localparam logic [3:0] NRM = 4'b1100, STL = 4'b0001, BRT = 4'b1110, WT = 4'b0000;

    typedef struct packed {
        logic [3:0] sa, sb, sd;
        logic       ua, ub, ud, rfld;
        logic [3:0] dest;
        logic       ld, br, mw;
        logic [1:0] sel_a, sel_b, sel_d;
        logic [3:0] ctl;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                                input logic xa, input logic xb, input logic xd, input logic rf,
                                input logic [3:0] de, input logic l, input logic bt, input logic w,
                                input logic [1:0] qa, input logic [1:0] qb, input logic [1:0] qd,
                                input logic [3:0] c);
        return '{sa: a, sb: b, sd: d, ua: xa, ub: xb, ud: xd, rfld: rf, dest: de, ld: l,
                 br: bt, mw: w, sel_a: qa, sel_b: qb, sel_d: qd, ctl: c};
    endfunction

    function automatic logic [31:0] sel_val(input logic [1:0] s, input logic [31:0] port);
        case (s)
            S_E:     return exr;
            S_M:     return memr;
            S_W:     return wbr;
            default: return port;
        endcase
    endfunction

    vec_t tbl [22];

    task automatic set_vec(input vec_t v);
        sa = v.sa; sb = v.sb; sd = v.sd; ua = v.ua; ub = v.ub; ud = v.ud;
        rfld = v.rfld; dest = v.dest; ld = v.ld; br = v.br; mw = v.mw;
    endtask

    function automatic logic [3:0] rand_reg();
        int unsigned r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 4'd15 : 4'(r);
    endfunction

    initial begin
        // ALU R3, ALU R3, read R3 (+R15); load R5 / use; WB forward; branch; load-use+branch;
        // 3-cycle MEM_WAIT with MEMs valid; MEM_WAIT over a load-use; R15 writer never forwarded.
        tbl[0]  = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, S_P, S_P, S_P, NRM);
        tbl[1]  = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, S_P, S_P, S_P, NRM);
        tbl[2]  = mk(4'd3, 4'd15, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, S_E, S_P, S_P, NRM);
        tbl[3]  = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, S_P, S_P, S_P, NRM);
        tbl[4]  = mk(4'd0, 4'd5, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, S_P, S_P, S_P, STL);
        tbl[5]  = mk(4'd0, 4'd5, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, S_P, S_M, S_P, NRM);
        tbl[6]  = mk(4'd6, 4'd0, 4'd5,  1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, S_E, S_P, S_W, NRM);
        tbl[7]  = mk(4'd6, 4'd0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, S_M, S_P, S_P, BRT);
        tbl[8]  = mk(4'd0, 4'd6, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, S_P, S_W, S_P, NRM);
        tbl[9]  = mk(4'd2, 4'd0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, S_P, S_P, S_P, STL);
        tbl[10] = mk(4'd2, 4'd0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, S_M, S_P, S_P, BRT);
        tbl[11] = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, S_P, S_P, S_P, NRM);
        tbl[12] = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, S_P, S_P, S_P, NRM);
        tbl[13] = mk(4'd4, 4'd0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1, S_M, S_P, S_P, WT);
        tbl[14] = mk(4'd4, 4'd0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1, S_M, S_P, S_P, WT);
        tbl[15] = mk(4'd4, 4'd0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1, S_M, S_P, S_P, WT);
        tbl[16] = mk(4'd4, 4'd0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, S_M, S_P, S_P, NRM);
        tbl[17] = mk(4'd4, 4'd15, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, S_W, S_P, S_E, NRM);
        tbl[18] = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, S_P, S_P, S_P, NRM);
        tbl[19] = mk(4'd1, 4'd0, 4'd8,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, S_P, S_P, S_P, WT);
        tbl[20] = mk(4'd1, 4'd0, 4'd8,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, S_P, S_P, S_P, STL);
        tbl[21] = mk(4'd1, 4'd0, 4'd8,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, S_M, S_P, S_P, NRM);

        // Reset behaviour
        model_reset();
        rst = 1'b1;
        set_vec(vec_t'(0));
        sa = 4'd3; ua = 1'b1;
        pa = 32'h0000_0011; pb = 32'hB0B0_0002; pd = 32'hD0D0_0003;
        exr = 32'h0000_0022; memr = 32'h0000_0011; wbr = 32'h7777_0007;
        #1;
        check_outputs("reset", 32'h0000_0011, pb, pd, 4'b1100);
        check_count("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_outputs("post_reset", 32'h0000_0011, pb, pd, 4'b1100);
        pa = 32'hA0A0_0001;

        // Directed table
        for (int i = 0; i < 22; i++) begin
            set_vec(tbl[i]);
            #1;
            check_outputs($sformatf("vec%0d", i), sel_val(tbl[i].sel_a, pa),
                          sel_val(tbl[i].sel_b, pb), sel_val(tbl[i].sel_d, pd), tbl[i].ctl);
            check_count($sformatf("vec%0d", i));
            tick();
        end

        // Reset asserted in the middle of a load-use stall
        set_vec(mk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0,
                   S_P, S_P, S_P, NRM));
        #1;
        tick();
        rfld = 1'b0; ld = 1'b0; sb = 4'd5; ub = 1'b1;
        #1;
        check_outputs("pre_rst_stall", pa, pb, pd, STL);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rst_mid_stall", pa, pb, pd, NRM);
        check_count("rst_mid_stall");
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            sa = rand_reg(); sb = rand_reg(); sd = rand_reg(); dest = rand_reg();
            ua = 1'($urandom_range(0, 1)); ub = 1'($urandom_range(0, 1));
            ud = 1'($urandom_range(0, 1)); rfld = 1'($urandom_range(0, 1));
            ld = 1'($urandom_range(0, 1));
            br = ($urandom_range(0, 3) == 0);
            mw = ($urandom_range(0, 7) == 0);
            pa = $urandom(); pb = $urandom(); pd = $urandom();
            exr = $urandom(); memr = $urandom(); wbr = $urandom();
            #1;
            check_model($sformatf("rnd%0d", n));
            tick();
        end

`ifdef HZ_PERF_CNT_EN
        // Long memory wait saturates the stall counter
        mw = 1'b1;
        repeat (70000) tick();
        chk("saturate.cnt", {16'd0, stall_count}, 32'h0000_FFFF);
        check_model("saturate");
        mw = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
